// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry register,
// consuming operands LSB first and presenting {c_out, sum} with a done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             accept, last, s, cy_next;

    always_comb begin
        accept  = start && (state == IDLE || state == DONE);
        last    = (state == RUN) && (cnt == CW'(WIDTH - 1));
        s       = a_sr[0] ^ b_sr[0] ^ cy;
        cy_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & cy) | (b_sr[0] & cy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last)   state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are flopped from the next state so they change exactly with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            cy    <= c_in;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            cy   <= cy_next;
            cnt  <= cnt + CW'(1);
            // sum fills from the MSB so step i lands in bit i after WIDTH shifts
            sum  <= {s, sum[WIDTH-1:1]};
            if (last) c_out <= cy_next;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         c_in;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         c_out;

    int checks   = 0;
    int failures = 0;
    int both_high = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) both_high++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; edges counts the accepting edge through the edge raising done.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                          output int edges, output int busy_cyc);
        a = ia; b = ib; c_in = ic; start = 1'b1;
        tick();
        start = 1'b0; a = $urandom; b = $urandom; c_in = $urandom;
        edges = 1; busy_cyc = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cyc++;
            tick();
            edges++;
        end
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t vecs[4] = '{
        '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0},
        '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1},
        '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1},
        '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0}
    };

    initial begin
        int e, bc, seen;
        logic [W-1:0] held;

        // Asynchronous reset before any rising edge
        rst_n = 1'b1; start = $urandom; a = $urandom; b = $urandom; c_in = $urandom;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", c_out, 0);
        start = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, e, bc);
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_sum", i), sum, vecs[i].s);
            chk($sformatf("v%0d_cout", i), c_out, vecs[i].co);
            if (i == 0) begin
                chk("lat_edges", e, W + 1);
                chk("busy_cycles", bc, W);
            end
            tick();
            chk($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // Sum holds while idle
        held = sum;
        repeat (4) tick();
        chk("sum_hold", sum, held);
        chk("cout_hold", c_out, 1'b0);

        // Start during RUN is ignored
        a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(e);
        chk("ign_done", done, 1);
        chk("ign_sum", sum, 8'h46);
        chk("ign_cout", c_out, 0);
        tick(); tick();
        chk("ign_no_restart", busy, 0);

        // Reset mid-RUN aborts with no done
        a = 8'hAA; b = 8'h55; c_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", c_out, 0);
        chk("mid_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (done || busy) seen++;
        end
        chk("mid_rst_no_done", seen, 0);
        run_op(8'h01, 8'h01, 1'b0, e, bc);
        chk("post_rst_sum", sum, 8'h02);
        chk("post_rst_cout", c_out, 0);
        tick();

        // Back-to-back: start held through DONE
        run_op(8'h11, 8'h22, 1'b0, e, bc);
        chk("b2b_first_sum", sum, 8'h33);
        a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        wait_done(e);
        chk("b2b_spacing", e + 1, W + 1);
        chk("b2b_sum", sum, 8'h00);
        chk("b2b_cout", c_out, 1);
        tick();

        chk("busy_done_excl", both_high, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
